// File: rtl/pdp_trace_encoder_if.sv
// ---------------------------------------------------------------------------
// pdp_trace_encoder_if
//
// Purpose: bundles the two streams that pass through the trace encoder.
//   - Access side: memory-access events coming from the PDP-11 CPU model.
//   - Trace side: encoded trace words going to the trace-file writer.
//
// Signals:
//   acc_valid    access event present this cycle
//   acc_type     0 = data read, 1 = data write, 2 = instruction fetch, 3 = reserved
//   acc_addr     byte address of the access
//   acc_byte     1 = byte access, 0 = word access
//   trace_valid  trace_word holds an unconsumed entry
//   trace_ready  downstream accepts trace_word this cycle
//   trace_word   {type[1:0], addr[15:0]}
//
// Modports:
//   master  the environment: drives accesses and trace_ready
//   slave   the encoder: consumes accesses, produces trace words
// ---------------------------------------------------------------------------
interface pdp_trace_encoder_if;
    logic        acc_valid;
    logic [1:0]  acc_type;
    logic [15:0] acc_addr;
    logic        acc_byte;
    logic        trace_valid;
    logic        trace_ready;
    logic [17:0] trace_word;

    modport master (
        output acc_valid,
        output acc_type,
        output acc_addr,
        output acc_byte,
        output trace_ready,
        input  trace_valid,
        input  trace_word
    );

    modport slave (
        input  acc_valid,
        input  acc_type,
        input  acc_addr,
        input  acc_byte,
        input  trace_ready,
        output trace_valid,
        output trace_word
    );
endinterface

// File: rtl/pdp_trace_encoder.sv
// ---------------------------------------------------------------------------
// pdp_trace_encoder
//
// Purpose: captures PDP-11 memory-access events (data read, data write,
// instruction fetch), encodes each as an 18-bit trace word
// {type[1:0], addr[15:0]}, buffers the words in a show-ahead FIFO and hands
// them to the trace-file writer one per valid/ready handshake. Word accesses
// to odd addresses and the reserved access type are rejected and flagged.
// Per-type statistics count every access that enters the FIFO.
//
// Parameters:
//   DEPTH   FIFO entries, power of two, 2..64
//   CNT_W   width of each statistics counter
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   bus         pdp_trace_encoder_if.slave (access stream in, trace stream out)
//   fifo_level  current number of buffered entries
//   overflow    sticky, a legal access was dropped because the FIFO was full
//   odd_err     one-cycle pulse after an illegal access
//   stat_clr    synchronous clear of the counters and overflow
//   rd_count    accepted data reads (saturating)
//   wr_count    accepted data writes (saturating)
//   if_count    accepted instruction fetches (saturating)
// ---------------------------------------------------------------------------
module pdp_trace_encoder #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pdp_trace_encoder_if.slave       bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     odd_err,
    input  logic                     stat_clr,
    output logic [CNT_W-1:0]         rd_count,
    output logic [CNT_W-1:0]         wr_count,
    output logic [CNT_W-1:0]         if_count
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_LVL = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    localparam logic [1:0] TYPE_READ  = 2'd0;
    localparam logic [1:0] TYPE_WRITE = 2'd1;
    localparam logic [1:0] TYPE_FETCH = 2'd2;
    localparam logic [1:0] TYPE_RSVD  = 2'd3;

    logic [17:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [17:0]      last_word;

    logic legal;
    logic is_full;
    logic is_empty;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Classify the incoming access and decide what happens to it this cycle.
    // A full FIFO still accepts a push when the head is leaving in the same
    // cycle, because the pop frees exactly the slot the push needs.
    always_comb begin
        legal    = bus.acc_valid && (bus.acc_type != TYPE_RSVD)
                   && (bus.acc_byte || !bus.acc_addr[0]);
        is_full  = (fifo_level == FULL_LVL);
        is_empty = (fifo_level == '0);
        do_pop   = !is_empty && bus.trace_ready;
        do_push  = legal && (!is_full || do_pop);
        do_drop  = legal && is_full && !do_pop;
    end

    // Show-ahead output: the head entry is presented straight from storage.
    // When the FIFO runs dry the last consumed word is held so the downstream
    // side never sees stale storage contents. Every term here comes from a
    // register, so nothing on the access side reaches the trace side within
    // the same cycle.
    always_comb begin
        bus.trace_valid = !is_empty;
        bus.trace_word  = is_empty ? last_word : mem[rd_ptr];
    end

    // Entry storage. It is deliberately not reset: validity is tracked by
    // fifo_level, and the empty-case output comes from last_word.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {bus.acc_type, bus.acc_addr};
        end
    end

    // Pointers, occupancy and the held copy of the last consumed word.
    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH on
    // their own; fifo_level carries the extra bit that tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            last_word  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_word <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   fifo_level <= fifo_level + (PTR_W + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (PTR_W + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Rejected-access pulse: high for exactly the cycle after an illegal
    // access, low otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odd_err <= 1'b0;
        end else begin
            odd_err <= bus.acc_valid && !legal;
        end
    end

    // Sticky overflow flag. A clear in the same cycle as a drop wins, so the
    // flag only reflects drops that happen after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (stat_clr) begin
            overflow <= 1'b0;
        end else if (do_drop) begin
            overflow <= 1'b1;
        end
    end

    // Saturating per-type statistics. Only accesses that actually enter the
    // FIFO are counted, so the counts match what the writer will log. A clear
    // coinciding with a push zeroes the counter; the entry is still enqueued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
            if_count <= '0;
        end else if (stat_clr) begin
            rd_count <= '0;
            wr_count <= '0;
            if_count <= '0;
        end else if (do_push) begin
            case (bus.acc_type)
                TYPE_READ: begin
                    if (rd_count != CNT_MAX) begin
                        rd_count <= rd_count + CNT_W'(1);
                    end
                end
                TYPE_WRITE: begin
                    if (wr_count != CNT_MAX) begin
                        wr_count <= wr_count + CNT_W'(1);
                    end
                end
                TYPE_FETCH: begin
                    if (if_count != CNT_MAX) begin
                        if_count <= if_count + CNT_W'(1);
                    end
                end
                default: begin
                    rd_count <= rd_count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdp_trace_encoder.sv
// ---------------------------------------------------------------------------
// tb_pdp_trace_encoder
//
// Directed and randomized stimulus for pdp_trace_encoder (DEPTH = 8,
// CNT_W = 4 so counter saturation is reachable). Expected values come from a
// queue-based model of the trace path built from the access rules.
// ---------------------------------------------------------------------------
module tb_pdp_trace_encoder;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stat_clr = 1'b0;
    logic [3:0]       fifo_level;
    logic             overflow;
    logic             odd_err;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;
    logic [CNT_W-1:0] if_count;

    pdp_trace_encoder_if bus ();

    pdp_trace_encoder #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .odd_err   (odd_err),
        .stat_clr  (stat_clr),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .if_count  (if_count)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: the list of words waiting to be logged, the word
    // last handed downstream, per-type counts and the two status flags.
    logic [17:0] mq[$];
    logic [17:0] m_last;
    int          m_cnt[3];
    logic        m_ovf;
    logic        m_odd;

    // One comparison: counts it, and counts and reports it if it differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_last = '0;
        m_cnt  = '{0, 0, 0};
        m_ovf  = 1'b0;
        m_odd  = 1'b0;
    endtask

    // What one clock edge does to the model, given the inputs seen there.
    task automatic modelEdge(input logic v, input logic [1:0] t, input logic [15:0] a,
                             input logic b, input logic r, input logic c);
        bit legal;
        bit pop;
        bit had_room;
        legal    = v && (t != 2'd3) && (b || !a[0]);
        pop      = (mq.size() != 0) && r;
        had_room = mq.size() < DEPTH;
        if (pop) m_last = mq.pop_front();
        if (legal && (had_room || pop)) begin
            mq.push_back({t, a});
            if (m_cnt[t] < CNT_MAX) m_cnt[t]++;
        end else if (legal) begin
            m_ovf = 1'b1;
        end
        m_odd = v && !legal;
        if (c) begin
            m_cnt = '{0, 0, 0};
            m_ovf = 1'b0;
        end
    endtask

    task automatic checkAll(input string where);
        logic [17:0] exp_word;
        exp_word = (mq.size() != 0) ? mq[0] : m_last;
        checkOutput({where, ".trace_valid"}, 32'(bus.trace_valid), 32'(mq.size() != 0));
        checkOutput({where, ".trace_word"},  32'(bus.trace_word),  32'(exp_word));
        checkOutput({where, ".fifo_level"},  32'(fifo_level),      32'(mq.size()));
        checkOutput({where, ".overflow"},    32'(overflow),        32'(m_ovf));
        checkOutput({where, ".odd_err"},     32'(odd_err),         32'(m_odd));
        checkOutput({where, ".rd_count"},    32'(rd_count),        32'(m_cnt[0]));
        checkOutput({where, ".wr_count"},    32'(wr_count),        32'(m_cnt[1]));
        checkOutput({where, ".if_count"},    32'(if_count),        32'(m_cnt[2]));
    endtask

    // Drive one cycle of inputs after the falling edge, let the rising edge
    // happen, advance the model and compare shortly after the edge.
    task automatic applyStimulus(input logic v, input logic [1:0] t, input logic [15:0] a,
                                 input logic b, input logic r, input logic c,
                                 input string where);
        @(negedge clk);
        bus.acc_valid   = v;
        bus.acc_type    = t;
        bus.acc_addr    = a;
        bus.acc_byte    = b;
        bus.trace_ready = r;
        stat_clr        = c;
        @(posedge clk);
        modelEdge(v, t, a, b, r, c);
        #1;
        checkAll(where);
    endtask

    task automatic idleInputs();
        bus.acc_valid   = 1'b0;
        bus.acc_type    = 2'd0;
        bus.acc_addr    = 16'd0;
        bus.acc_byte    = 1'b0;
        bus.trace_ready = 1'b0;
        stat_clr        = 1'b0;
    endtask

    initial begin
        logic [15:0] addr;
        logic        rv;
        logic [1:0]  rt;
        logic        rb;
        logic        rr;
        logic        rc;

        // Power-on reset.
        idleInputs();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch, read, write with the writer always ready.
        applyStimulus(1'b1, 2'd2, 16'o001000, 1'b0, 1'b1, 1'b0, "fetch");
        checkOutput("fetch_word", 32'(bus.trace_word), 32'({2'd2, 16'o001000}));
        applyStimulus(1'b1, 2'd0, 16'o001002, 1'b0, 1'b1, 1'b0, "read");
        checkOutput("read_word", 32'(bus.trace_word), 32'({2'd0, 16'o001002}));
        applyStimulus(1'b1, 2'd1, 16'o177776, 1'b0, 1'b1, 1'b0, "write");
        checkOutput("write_word", 32'(bus.trace_word), 32'({2'd1, 16'o177776}));
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, "drain3");
        checkOutput("counts_111", 32'({rd_count, wr_count, if_count}), 32'(12'h111));

        // Ten reads into a stalled FIFO: eight kept, overflow raised.
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1, "clr1");
        for (int i = 0; i < 10; i++) begin
            addr = 16'(16'o002000 + 2 * i);
            applyStimulus(1'b1, 2'd0, addr, 1'b0, 1'b0, 1'b0, "fill10");
        end
        checkOutput("full_level", 32'(fifo_level), 32'(DEPTH));
        checkOutput("full_ovf", 32'(overflow), 32'd1);
        checkOutput("full_rd", 32'(rd_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            addr = 16'(16'o002000 + 2 * i);
            checkOutput("drain_order", 32'(bus.trace_word), 32'({2'd0, addr}));
            applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, "drain8");
        end
        checkOutput("drain_empty", 32'(bus.trace_valid), 32'd0);

        // Alignment and reserved-type rejection.
        applyStimulus(1'b1, 2'd0, 16'o001001, 1'b0, 1'b1, 1'b0, "odd_word");
        checkOutput("odd_word_err", 32'(odd_err), 32'd1);
        applyStimulus(1'b1, 2'd0, 16'o001001, 1'b1, 1'b1, 1'b0, "odd_byte");
        checkOutput("odd_byte_word", 32'(bus.trace_word), 32'({2'd0, 16'o001001}));
        checkOutput("odd_byte_noerr", 32'(odd_err), 32'd0);
        applyStimulus(1'b1, 2'd3, 16'o000100, 1'b0, 1'b1, 1'b0, "reserved");
        checkOutput("reserved_err", 32'(odd_err), 32'd1);
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, "err_idle");

        // Full FIFO with simultaneous push and pop across pointer wrap.
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b1, "clr2");
        for (int i = 0; i < DEPTH; i++) begin
            addr = 16'(16'o010000 + 2 * i);
            applyStimulus(1'b1, 2'd1, addr, 1'b0, 1'b0, 1'b0, "fill8");
        end
        for (int i = 0; i < 20; i++) begin
            addr = 16'($urandom) & 16'hfffe;
            applyStimulus(1'b1, 2'd0, addr, 1'b0, 1'b1, 1'b0, "pushpop");
        end
        checkOutput("pushpop_level", 32'(fifo_level), 32'(DEPTH));
        checkOutput("pushpop_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, "drain_wrap");
        end

        // Clear coinciding with a fetch push.
        applyStimulus(1'b1, 2'd2, 16'o004000, 1'b0, 1'b0, 1'b1, "clr_fetch");
        checkOutput("clr_fetch_cnt", 32'(if_count), 32'd0);
        checkOutput("clr_fetch_word", 32'(bus.trace_word), 32'({2'd2, 16'o004000}));
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, "clr_fetch_pop");

        // Counter saturation.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            applyStimulus(1'b1, 2'd0, 16'o000200, 1'b0, 1'b1, 1'b0, "saturate");
        end
        checkOutput("sat_rd", 32'(rd_count), 32'(CNT_MAX));

        // Randomized traffic with occasional stalls and clears.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rt = 2'($urandom_range(0, 3));
            rb = 1'($urandom_range(0, 1));
            rr = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 40) == 0);
            applyStimulus(rv, rt, 16'($urandom), rb, rr, rc, "random");
        end

        // Asynchronous reset with five entries buffered.
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, "pre_fill5");
        end
        for (int i = 0; i < 5; i++) begin
            addr = 16'(16'o020000 + 2 * i);
            applyStimulus(1'b1, 2'd2, addr, 1'b0, 1'b0, 1'b0, "fill5");
        end
        checkOutput("fill5_level", 32'(fifo_level), 32'd5);
        @(negedge clk);
        idleInputs();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_valid", 32'(bus.trace_valid), 32'd0);
        checkOutput("async_level", 32'(fifo_level), 32'd0);
        checkAll("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdp_trace_encoder.md
Name: pdp_trace_encoder

Overview:
- Sits directly upstream of the simulator's trace-file writer.
- Captures memory-access events from the PDP-11 CPU model: data read, data write and instruction fetch.
- Encodes each event as an 18-bit trace word {type[1:0], addr[15:0]}, buffers the words in a FIFO and hands them downstream one per handshake.
- Also checks word-access alignment and keeps per-type access statistics.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- CNT_W, 32: width of each statistics counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- acc_valid  in  1  access event present this cycle.
- acc_type  in  2  0 = data read, 1 = data write, 2 = instruction fetch, 3 = reserved.
- acc_addr  in  16  byte address of the access.
- acc_byte  in  1  1 = byte access, 0 = word access.
- trace_valid  out  1  trace_word holds an unconsumed entry.
- trace_ready  in  1  downstream accepts trace_word this cycle.
- trace_word  out  18  [17:16] = type, [15:0] = address.
- fifo_level  out  $clog2(DEPTH)+1  current number of entries.
- overflow  out  1  sticky: an access was dropped because the FIFO was full.
- odd_err  out  1  one-cycle pulse: odd-address word access or reserved type.
- stat_clr  in  1  synchronous clear of counters and overflow.
- rd_count, wr_count, if_count  out  CNT_W each  accepted reads, writes and fetches.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; trace_valid = 0; trace_word = 0; fifo_level = 0.
  - overflow = 0; odd_err = 0; all counters = 0.
  - Reset mid-operation discards all buffered entries immediately.
- Legal access: acc_valid = 1 and acc_type != 3 and (acc_byte = 1 or acc_addr[0] = 0).
- Illegal access (acc_valid = 1, not legal):
  - Not enqueued; counters unchanged.
  - odd_err = 1 in the cycle after the event; otherwise odd_err = 0.
- Push: a legal access with FIFO not full writes {acc_type, acc_addr} at the tail.
- Pop: occurs when trace_valid && trace_ready; head advances.
- Show-ahead output:
  - trace_word always equals the head entry. When empty it holds the last popped value, or 0 after reset.
  - trace_valid = (fifo_level != 0).
- Latency: an access pushed at edge N is visible on trace_word / trace_valid after edge N (one cycle).
  - No combinational path from acc_* to trace_*.
- trace_word is stable while trace_valid = 1 and trace_ready = 0.
- Simultaneous push and pop:
  - Both happen; fifo_level unchanged.
  - Allowed when full: the pop frees the slot, so the push is accepted and overflow is not set.
  - When empty with a push, the new entry does not bypass; it appears next cycle.
- Full (fifo_level = DEPTH), legal access, no pop:
  - Access dropped; overflow set to 1 (sticky); counters unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Order is strictly FIFO across wrap.
- Counters:
  - Increment by 1 on each push of the matching type.
  - Saturate at 2^CNT_W - 1 (no wrap).
- stat_clr:
  - Next edge zeroes all counters and overflow; FIFO contents untouched.
  - If a push coincides with stat_clr, clear wins: counter = 0 and the entry is still enqueued.
  - If an overflow coincides with stat_clr, clear wins: overflow = 0.
- Downstream writer prints each consumed word as "type address" in octal; this block guarantees exactly one trace_valid && trace_ready handshake per logged access.

Test Plan:
- Reset, then fetch 0o001000, read 0o001002, write 0o177776 (word), trace_ready = 1 → words 2/001000, 0/001002, 1/177776 each one cycle after input; counts 1/1/1.
- trace_ready = 0, push 10 legal reads, DEPTH = 8 → fifo_level = 8, overflow = 1, rd_count = 8; then drain → exactly 8 words in order, addresses of the first 8.
- Word read at 0o001001 → no enqueue, odd_err pulse; byte read at 0o001001 → enqueued as 0/001001; acc_type = 3 → odd_err pulse, no enqueue.
- FIFO full with push and pop in the same cycle → fifo_level stays 8, overflow stays 0; 20 push/pop cycles across pointer wrap preserve order.
- stat_clr coincident with a fetch push → if_count = 0, entry still output; assert rst_n low with 5 entries buffered → trace_valid = 0 and fifo_level = 0 immediately.
- Force rd_count to 2^CNT_W - 1 (CNT_W = 4 build: 15), push a read → count stays 15.
